io_handshake_port: RTL and testbench
====================================

Name: io_handshake_port

Overview:
- Byte-wide I/O peripheral attached to the processor's external bus pins.
- Feeds the processor's bus_in/hs_in and consumes its bus_out/hs_out.
- Buffers traffic in both directions between the processor's four-phase handshake and a device-side valid/ready stream, using one RX FIFO and one TX FIFO.
- Raises the processor's ext_int when received data is waiting.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.
- INT_LEVEL, 1, RX occupancy at or above which ext_int asserts; range 1..DEPTH.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_clr  in  1  global clear; asynchronous, active-low.
- cpu_bus_out  in  8  byte from the processor's bus_out (R_OUT).
- cpu_hs_out  in  1  processor request, four-phase.
- cpu_dir  in  1  transfer direction, from controller decode: 0 = processor reads port, 1 = processor writes port; sampled only in IDLE.
- cpu_bus_in  out  8  byte to the processor's bus_in (registered).
- cpu_hs_in  out  1  port acknowledge to the processor's hs_in (registered).
- ext_int  out  1  interrupt request to the processor's ext_int (registered).
- dev_rx_data  in  8  incoming device byte.
- dev_rx_valid  in  1  device byte valid.
- dev_rx_ready  out  1  RX FIFO can accept a byte.
- dev_tx_data  out  8  head of TX FIFO.
- dev_tx_valid  out  1  TX FIFO non-empty.
- dev_tx_ready  in  1  device accepts the byte.
- rx_count  out  AW+1  RX occupancy.
- tx_count  out  AW+1  TX occupancy.

Behaviour:
- Reset is asynchronous on g_clr=0. Reset values:
  - cpu_bus_in=0, cpu_hs_in=0, ext_int=0.
  - Both FIFOs empty, pointers=0, rx_count=tx_count=0.
  - dev_rx_ready=1, dev_tx_valid=0, dev_tx_data=0.
  - FSM=IDLE.
- Reset mid-handshake: cpu_hs_in drops immediately; all FIFO contents are discarded.
- Each FIFO is circular, with read/write pointers of AW bits that wrap DEPTH-1 -> 0, and an occupancy counter of AW+1 bits.
  - full = (count==DEPTH); empty = (count==0).
  - Simultaneous push and pop in the same cycle: both pointers advance, count unchanged.
- RX push: dev_rx_valid & dev_rx_ready.
  - dev_rx_ready = !rx_full. It is not raised early by a same-cycle pop, so no data is ever dropped.
- TX pop: dev_tx_valid & dev_tx_ready.
  - dev_tx_valid = !tx_empty; dev_tx_data = TX head entry.
  - A pushed byte appears on dev_tx_valid the cycle after the push edge.
- CPU FSM, states IDLE, ACK:
  - IDLE, cpu_hs_out=1, cpu_dir=0, rx not empty: cpu_bus_in <= RX head, pop RX, cpu_hs_in <= 1, go to ACK.
  - IDLE, cpu_hs_out=1, cpu_dir=0, rx empty: stay IDLE with cpu_hs_in=0; the processor stalls until a byte arrives.
  - IDLE, cpu_hs_out=1, cpu_dir=1, tx not full: push cpu_bus_out into TX, cpu_hs_in <= 1, go to ACK.
  - IDLE, cpu_hs_out=1, cpu_dir=1, tx full: stall in IDLE.
  - ACK: hold cpu_hs_in=1 and hold cpu_bus_in until cpu_hs_out=0; then cpu_hs_in <= 0 and go to IDLE.
  - Minimum handshake latency is 1 cycle from request to ack. A new request is not serviced until the cycle after cpu_hs_in falls.
  - cpu_dir changes while in ACK are ignored.
- A CPU pop and a device push on RX in the same cycle is legal; count is unchanged. The same rule applies to a CPU push and a device pop on TX.
- ext_int <= (rx_count_next >= INT_LEVEL), registered.
  - It deasserts the cycle after the pop that takes occupancy below INT_LEVEL.
- Data ordering is strict FIFO in each direction. The processor never observes a byte out of order or duplicated.

Test Plan:
1. Reset/idle:
   - Stimulus: g_clr pulsed low mid-cycle during ACK with rx holding 2 bytes.
   - Response: cpu_hs_in=0 immediately, rx_count=0, dev_rx_ready=1, ext_int=0.
2. RX path:
   - Stimulus: device pushes 0x11, 0x22, 0x33; processor does three read handshakes (cpu_dir=0).
   - Response: cpu_bus_in shows 0x11, 0x22, 0x33 in order, each with cpu_hs_in rising 1 cycle after cpu_hs_out; ext_int=1 from the cycle after the first push until the cycle after the last pop (INT_LEVEL=1).
3. RX full/stall:
   - Stimulus: device pushes 5 bytes 0xA0..0xA4 with DEPTH=4.
   - Response: dev_rx_ready=0 after the 4th; the 5th is held by the device until the first CPU read, then accepted; rx_count stays 4.
   - Stimulus: a read request on empty RX.
   - Response: cpu_hs_in stays 0 until a byte arrives, then acks with it.
4. TX path:
   - Stimulus: processor writes 0x5A, 0xC3 with dev_tx_ready=0.
   - Response: tx_count=2, dev_tx_valid=1, dev_tx_data=0x5A.
   - Stimulus: dev_tx_ready=1.
   - Response: device receives 0x5A then 0xC3, then dev_tx_valid=0.
5. TX full:
   - Stimulus: 5 writes with dev_tx_ready=0.
   - Response: the 5th request gets no ack until one device pop; tx_count never exceeds 4; pointer wrap verified by 10 total bytes passing intact.
6. Simultaneous events:
   - Stimulus: RX holds 1 byte; device push and CPU pop in the same cycle.
   - Response: rx_count stays 1, ext_int stays 1, next read returns the pushed byte.

Source files
------------

// File: rtl/io_handshake_port.sv
// Byte-wide processor I/O port: bridges the four-phase cpu_hs_out/cpu_hs_in
// handshake to device-side valid/ready streams through one RX and one TX FIFO.
module io_handshake_port #(
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter int INT_LEVEL = 1
) (
   input  logic          g_clk,
   input  logic          g_clr,
   input  logic [7:0]    cpu_bus_out,
   input  logic          cpu_hs_out,
   input  logic          cpu_dir,
   output logic [7:0]    cpu_bus_in,
   output logic          cpu_hs_in,
   output logic          ext_int,
   input  logic [7:0]    dev_rx_data,
   input  logic          dev_rx_valid,
   output logic          dev_rx_ready,
   output logic [7:0]    dev_tx_data,
   output logic          dev_tx_valid,
   input  logic          dev_tx_ready,
   output logic [AW:0]   rx_count,
   output logic [AW:0]   tx_count
);

   // state | meaning
   // IDLE  | waiting for cpu_hs_out; services it once the FIFO allows
   // ACK   | cpu_hs_in held high until the processor drops cpu_hs_out
   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] INT_LVL = INT_LEVEL[AW:0];

   state_t        state;

   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] rx_wr_ptr;
   logic [AW-1:0] rx_rd_ptr;
   logic [AW:0]   rx_count_next;
   logic          rx_full;
   logic          rx_empty;
   logic          rx_push;
   logic          rx_pop;

   logic [7:0]    tx_mem [DEPTH];
   logic [AW-1:0] tx_wr_ptr;
   logic [AW-1:0] tx_rd_ptr;
   logic [AW:0]   tx_count_next;
   logic          tx_full;
   logic          tx_empty;
   logic          tx_push;
   logic          tx_pop;

   assign rx_full      = (rx_count == DEPTH_C);
   assign rx_empty     = (rx_count == '0);
   assign tx_full      = (tx_count == DEPTH_C);
   assign tx_empty     = (tx_count == '0);

   // Ready reflects registered occupancy only, so a same-cycle CPU pop never
   // lets the device push into a slot that is still occupied.
   assign dev_rx_ready = !rx_full;
   assign dev_tx_valid = !tx_empty;
   assign dev_tx_data  = tx_mem[tx_rd_ptr];

   assign rx_push = dev_rx_valid && dev_rx_ready;
   assign tx_pop  = dev_tx_valid && dev_tx_ready;
   assign rx_pop  = (state == IDLE) && cpu_hs_out && !cpu_dir && !rx_empty;
   assign tx_push = (state == IDLE) && cpu_hs_out &&  cpu_dir && !tx_full;

   always_comb begin
      rx_count_next = rx_count;
      if (rx_push && !rx_pop) begin
         rx_count_next = rx_count + 1'b1;
      end else if (rx_pop && !rx_push) begin
         rx_count_next = rx_count - 1'b1;
      end
   end

   always_comb begin
      tx_count_next = tx_count;
      if (tx_push && !tx_pop) begin
         tx_count_next = tx_count + 1'b1;
      end else if (tx_pop && !tx_push) begin
         tx_count_next = tx_count - 1'b1;
      end
   end

   always_ff @(posedge g_clk) begin
      if (rx_push) begin
         rx_mem[rx_wr_ptr] <= dev_rx_data;
      end
   end

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         ext_int   <= 1'b0;
      end else begin
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + 1'b1;
         end
         rx_count <= rx_count_next;
         ext_int  <= (rx_count_next >= INT_LVL);
      end
   end

   // TX storage is cleared so dev_tx_data reads zero straight out of reset.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem[i] <= '0;
         end
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wr_ptr] <= cpu_bus_out;
            tx_wr_ptr         <= tx_wr_ptr + 1'b1;
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + 1'b1;
         end
         tx_count <= tx_count_next;
      end
   end

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         state      <= IDLE;
         cpu_bus_in <= '0;
         cpu_hs_in  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_pop) begin
                  cpu_bus_in <= rx_mem[rx_rd_ptr];
                  cpu_hs_in  <= 1'b1;
                  state      <= ACK;
               end else if (tx_push) begin
                  cpu_hs_in  <= 1'b1;
                  state      <= ACK;
               end
            end
            ACK: begin
               if (!cpu_hs_out) begin
                  cpu_hs_in <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               cpu_hs_in <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_handshake_port.sv
// Bench for io_handshake_port: vector table, directed corner sequences and
// random traffic checked against a queue-based model of the port.
module tb_io_handshake_port;
   localparam int DEPTH     = 4;
   localparam int AW        = 2;
   localparam int INT_LEVEL = 1;

   logic          g_clk = 1'b0;
   logic          g_clr;
   logic [7:0]    cpu_bus_out;
   logic          cpu_hs_out;
   logic          cpu_dir;
   logic [7:0]    cpu_bus_in;
   logic          cpu_hs_in;
   logic          ext_int;
   logic [7:0]    dev_rx_data;
   logic          dev_rx_valid;
   logic          dev_rx_ready;
   logic [7:0]    dev_tx_data;
   logic          dev_tx_valid;
   logic          dev_tx_ready;
   logic [AW:0]   rx_count;
   logic [AW:0]   tx_count;

   int total = 0;
   int bad   = 0;

   always #5 g_clk = ~g_clk;

   io_handshake_port #(.DEPTH(DEPTH), .AW(AW), .INT_LEVEL(INT_LEVEL)) dut (
      .g_clk(g_clk), .g_clr(g_clr),
      .cpu_bus_out(cpu_bus_out), .cpu_hs_out(cpu_hs_out), .cpu_dir(cpu_dir),
      .cpu_bus_in(cpu_bus_in), .cpu_hs_in(cpu_hs_in), .ext_int(ext_int),
      .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
      .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready),
      .rx_count(rx_count), .tx_count(tx_count)
   );

   // reference model: byte queues plus "processor is being acknowledged"
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] tx_log[$];
   bit         m_ack;
   logic [7:0] m_bus;

   typedef struct {
      logic       rv;   logic [7:0] rd;  logic hs;  logic dir; logic [7:0] bo; logic txr;
      logic       e_hs; logic [7:0] e_bus; logic [2:0] e_rxc; logic [2:0] e_txc;
      logic       e_int; logic e_txv; logic [7:0] e_txd;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic hs,
                               input logic dir, input logic [7:0] bo, input logic txr,
                               input logic e_hs, input logic [7:0] e_bus, input logic [2:0] e_rxc,
                               input logic [2:0] e_txc, input logic e_int, input logic e_txv,
                               input logic [7:0] e_txd);
      vec_t v;
      v.rv = rv; v.rd = rd; v.hs = hs; v.dir = dir; v.bo = bo; v.txr = txr;
      v.e_hs = e_hs; v.e_bus = e_bus; v.e_rxc = e_rxc; v.e_txc = e_txc;
      v.e_int = e_int; v.e_txv = e_txv; v.e_txd = e_txd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      rx_q.delete();
      tx_q.delete();
      m_ack = 1'b0;
      m_bus = 8'h00;
   endtask

   // One clock: inputs held from the previous negedge, outputs checked at the next.
   task automatic cycle();
      bit         rxp, txp, rd, wr, rel;
      logic [7:0] rxd, bo;
      rxd = dev_rx_data;
      bo  = cpu_bus_out;
      rxp = dev_rx_valid && (rx_q.size() < DEPTH);
      txp = dev_tx_ready && (tx_q.size() > 0);
      rd  = !m_ack && cpu_hs_out && !cpu_dir && (rx_q.size() > 0);
      wr  = !m_ack && cpu_hs_out &&  cpu_dir && (tx_q.size() < DEPTH);
      rel = m_ack && !cpu_hs_out;
      if (dev_tx_valid && dev_tx_ready) tx_log.push_back(dev_tx_data);
      @(posedge g_clk);
      @(negedge g_clk);
      if (rd) begin
         m_bus = rx_q.pop_front();
         m_ack = 1'b1;
      end
      if (wr)  m_ack = 1'b1;
      if (rel) m_ack = 1'b0;
      if (txp) void'(tx_q.pop_front());
      if (wr)  tx_q.push_back(bo);
      if (rxp) rx_q.push_back(rxd);
      check("m_hs_in",    cpu_hs_in,    m_ack);
      check("m_bus_in",   cpu_bus_in,   m_bus);
      check("m_rx_count", rx_count,     rx_q.size());
      check("m_tx_count", tx_count,     tx_q.size());
      check("m_ext_int",  ext_int,      rx_q.size() >= INT_LEVEL);
      check("m_rx_ready", dev_rx_ready, rx_q.size() < DEPTH);
      check("m_tx_valid", dev_tx_valid, tx_q.size() > 0);
      if (tx_q.size() > 0) check("m_tx_data", dev_tx_data, tx_q[0]);
   endtask

   task automatic idle_inputs();
      cpu_bus_out = 8'h00; cpu_hs_out = 1'b0; cpu_dir = 1'b0;
      dev_rx_data = 8'h00; dev_rx_valid = 1'b0; dev_tx_ready = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] exp, input string nm);
      int n;
      cpu_dir = 1'b0; cpu_hs_out = 1'b1; n = 0;
      do begin cycle(); n++; end while (!cpu_hs_in && n < 40);
      check({nm, "_ack"}, cpu_hs_in, 1);
      check({nm, "_data"}, cpu_bus_in, exp);
      cpu_hs_out = 1'b0; n = 0;
      do begin cycle(); n++; end while (cpu_hs_in && n < 40);
      check({nm, "_rel"}, cpu_hs_in, 0);
   endtask

   task automatic cpu_write(input logic [7:0] d, input string nm);
      int n;
      cpu_dir = 1'b1; cpu_bus_out = d; cpu_hs_out = 1'b1; n = 0;
      do begin cycle(); n++; end while (!cpu_hs_in && n < 40);
      check({nm, "_ack"}, cpu_hs_in, 1);
      cpu_hs_out = 1'b0; n = 0;
      do begin cycle(); n++; end while (cpu_hs_in && n < 40);
      check({nm, "_rel"}, cpu_hs_in, 0);
   endtask

   initial begin
      tbl[0]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h00, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[1]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h00, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[2]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h00, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 8'h11, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h11, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 8'h22, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h22, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
      tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 8'h33, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
      tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h33, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
      tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0,  1'b1, 8'h33, 3'd0, 3'd1, 1'b0, 1'b1, 8'h5A);
      tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0,  1'b0, 8'h33, 3'd0, 3'd1, 1'b0, 1'b1, 8'h5A);
      tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0,  1'b1, 8'h33, 3'd0, 3'd2, 1'b0, 1'b1, 8'h5A);
      tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0,  1'b0, 8'h33, 3'd0, 3'd2, 1'b0, 1'b1, 8'h5A);
      tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1,  1'b0, 8'h33, 3'd0, 3'd1, 1'b0, 1'b1, 8'hC3);
      tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1,  1'b0, 8'h33, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
      tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 8'h33, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);

      // power-on reset
      idle_inputs();
      model_reset();
      g_clr = 1'b0;
      repeat (2) @(negedge g_clk);
      check("rst_hs_in",    cpu_hs_in,    0);
      check("rst_bus_in",   cpu_bus_in,   0);
      check("rst_ext_int",  ext_int,      0);
      check("rst_rx_count", rx_count,     0);
      check("rst_tx_count", tx_count,     0);
      check("rst_rx_ready", dev_rx_ready, 1);
      check("rst_tx_valid", dev_tx_valid, 0);
      check("rst_tx_data",  dev_tx_data,  0);
      g_clr = 1'b1;

      // RX then TX paths from the vector table
      for (int i = 0; i < 16; i++) begin
         dev_rx_valid = tbl[i].rv; dev_rx_data = tbl[i].rd;
         cpu_hs_out = tbl[i].hs; cpu_dir = tbl[i].dir; cpu_bus_out = tbl[i].bo;
         dev_tx_ready = tbl[i].txr;
         cycle();
         check($sformatf("tbl%0d_hs_in", i),    cpu_hs_in,    tbl[i].e_hs);
         check($sformatf("tbl%0d_bus_in", i),   cpu_bus_in,   tbl[i].e_bus);
         check($sformatf("tbl%0d_rx_count", i), rx_count,     tbl[i].e_rxc);
         check($sformatf("tbl%0d_tx_count", i), tx_count,     tbl[i].e_txc);
         check($sformatf("tbl%0d_ext_int", i),  ext_int,      tbl[i].e_int);
         check($sformatf("tbl%0d_tx_valid", i), dev_tx_valid, tbl[i].e_txv);
         if (tbl[i].e_txv) check($sformatf("tbl%0d_tx_data", i), dev_tx_data, tbl[i].e_txd);
      end
      idle_inputs();

      // asynchronous clear in the middle of an ACK with two RX bytes left
      for (int i = 0; i < 3; i++) begin
         dev_rx_valid = 1'b1; dev_rx_data = 8'h61 + 8'(i);
         cycle();
      end
      dev_rx_valid = 1'b0;
      cpu_dir = 1'b0; cpu_hs_out = 1'b1;
      cycle();
      check("clr_pre_ack", cpu_hs_in, 1);
      check("clr_pre_rxc", rx_count, 2);
      #2 g_clr = 1'b0;
      #1;
      check("clr_hs_in",    cpu_hs_in,    0);
      check("clr_rx_count", rx_count,     0);
      check("clr_rx_ready", dev_rx_ready, 1);
      check("clr_ext_int",  ext_int,      0);
      idle_inputs();
      model_reset();
      @(negedge g_clk);
      g_clr = 1'b1;

      // RX full: fifth byte waits for the first CPU read
      for (int i = 0; i < 4; i++) begin
         dev_rx_valid = 1'b1; dev_rx_data = 8'hA0 + 8'(i);
         cycle();
      end
      check("full_rx_ready", dev_rx_ready, 0);
      dev_rx_data = 8'hA4;
      repeat (2) begin
         cycle();
         check("full_rx_hold", rx_count, 4);
      end
      cpu_dir = 1'b0; cpu_hs_out = 1'b1;
      cycle();
      check("full_pop_data", cpu_bus_in, 8'hA0);
      check("full_pop_rxc",  rx_count, 3);
      cpu_hs_out = 1'b0;
      cycle();
      check("full_refill_rxc", rx_count, 4);
      dev_rx_valid = 1'b0;
      cycle();
      cpu_read(8'hA1, "full_rd1");
      cpu_read(8'hA2, "full_rd2");
      cpu_read(8'hA3, "full_rd3");
      cpu_read(8'hA4, "full_rd4");

      // read request on empty RX stalls until a byte arrives
      cpu_dir = 1'b0; cpu_hs_out = 1'b1;
      repeat (4) begin
         cycle();
         check("stall_rd_hs", cpu_hs_in, 0);
      end
      dev_rx_valid = 1'b1; dev_rx_data = 8'h77;
      cycle();
      check("stall_rd_push_hs", cpu_hs_in, 0);
      dev_rx_valid = 1'b0;
      cycle();
      check("stall_rd_ack",  cpu_hs_in, 1);
      check("stall_rd_data", cpu_bus_in, 8'h77);
      cpu_hs_out = 1'b0;
      cycle();

      // TX full stall plus ten bytes across the pointer wrap
      tx_log.delete();
      dev_tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) cpu_write(8'h30 + 8'(i), "txf_wr");
      cpu_dir = 1'b1; cpu_bus_out = 8'h34; cpu_hs_out = 1'b1;
      repeat (3) begin
         cycle();
         check("txf_stall_hs",  cpu_hs_in, 0);
         check("txf_stall_txc", tx_count, 4);
      end
      dev_tx_ready = 1'b1;
      cycle();
      check("txf_pop_hs",  cpu_hs_in, 0);
      check("txf_pop_txc", tx_count, 3);
      dev_tx_ready = 1'b0;
      cycle();
      check("txf_late_ack", cpu_hs_in, 1);
      check("txf_late_txc", tx_count, 4);
      cpu_hs_out = 1'b0;
      cycle();
      dev_tx_ready = 1'b1;
      repeat (6) cycle();
      check("txf_drained", tx_count, 0);
      for (int i = 5; i < 10; i++) cpu_write(8'h30 + 8'(i), "txw_wr");
      repeat (3) cycle();
      check("txw_count", tx_log.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < tx_log.size()) check($sformatf("txw_byte%0d", i), tx_log[i], 8'h30 + 8'(i));
      end
      idle_inputs();

      // simultaneous device push and CPU pop on RX
      dev_rx_valid = 1'b1; dev_rx_data = 8'h41;
      cycle();
      dev_rx_data = 8'h42; cpu_dir = 1'b0; cpu_hs_out = 1'b1;
      cycle();
      check("sim_data", cpu_bus_in, 8'h41);
      check("sim_rxc",  rx_count, 1);
      check("sim_int",  ext_int, 1);
      dev_rx_valid = 1'b0; cpu_hs_out = 1'b0;
      cycle();
      check("sim_rxc2", rx_count, 1);
      check("sim_int2", ext_int, 1);
      cpu_read(8'h42, "sim_rd");
      check("sim_int_off", ext_int, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         dev_rx_valid = 1'($urandom_range(0, 1));
         dev_rx_data  = 8'($urandom);
         dev_tx_ready = ($urandom_range(0, 3) != 0);
         cpu_hs_out   = ($urandom_range(0, 2) != 0);
         cpu_dir      = 1'($urandom_range(0, 1));
         cpu_bus_out  = 8'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
